// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : note_sequencer
//  Purpose  : Pattern sequencer for one synthesizer channel. Plays a small
//             writable pattern memory of notes (pitch, waveform, duration,
//             rest flag) at a programmable tempo. Runs on the divided clock.
//  Ports    : clk_div, rst (sync, active-high)
//             start/stop pulses, loop mode, tick_len (cycles per tick)
//             wr_en/wr_addr/wr_data : pattern memory write port
//                 wr_data = {rest[19], waveform[18:17], dur[16:12], pitch[11:0]}
//             pitch, waveform, mute : registered channel controls
//             busy, step_idx, note_strobe, done : status
//  Options  : SEQ_GATE_GAP_EN - mute the final tick of notes with dur>=2
//  Revision : 1.0 - initial release
// ============================================================================
module note_sequencer #(
    parameter int DEPTH  = 16,
    parameter int TICK_W = 16,
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic              clk_div,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [TICK_W-1:0] tick_len,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_addr,
    input  logic [19:0]       wr_data,
    output logic [11:0]       pitch,
    output logic [1:0]        waveform,
    output logic              mute,
    output logic              busy,
    output logic [IW-1:0]     step_idx,
    output logic              note_strobe,
    output logic              done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_PLAY  = 2'd2;

    logic [1:0]        r_state;
    logic [IW-1:0]     r_idx;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [TICK_W-1:0] r_tlen;
    logic [4:0]        r_dur_cnt;
    logic [4:0]        r_dur;

    // Pattern memory: deliberately not reset so contents survive rst.
    logic [19:0] r_mem [DEPTH];

    always_ff @(posedge clk_div) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // The entry is read during FETCH and captured at the FETCH edge; a write
    // to the same address on that edge lands afterwards, so old data is seen.
    logic [19:0] w_entry;
    logic        w_rest;
    logic [1:0]  w_wave;
    logic [4:0]  w_dur;
    logic [11:0] w_pitch;
    logic        w_tick_last;
    logic        w_dur_last;
    logic        w_gap_enter;

    assign w_entry     = r_mem[r_idx];
    assign w_rest      = w_entry[19];
    assign w_wave      = w_entry[18:17];
    assign w_dur       = w_entry[16:12];
    assign w_pitch     = w_entry[11:0];
    assign w_tick_last = (r_tick_cnt == r_tlen - TICK_W'(1));
    assign w_dur_last  = (r_dur_cnt == r_dur - 5'd1);

`ifdef SEQ_GATE_GAP_EN
    // Edge that enters the final tick: mute is registered, so it must be
    // raised one edge early to cover the whole last tick.
    assign w_gap_enter = w_tick_last && (r_dur >= 5'd2) && (r_dur_cnt == r_dur - 5'd2);
`else
    assign w_gap_enter = 1'b0;
`endif

    assign step_idx = r_idx;

    always_ff @(posedge clk_div) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_idx       <= '0;
            r_tick_cnt  <= '0;
            r_tlen      <= TICK_W'(1);
            r_dur_cnt   <= '0;
            r_dur       <= '0;
            pitch       <= '0;
            waveform    <= '0;
            mute        <= 1'b1;
            busy        <= 1'b0;
            note_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            done        <= 1'b0;
            if (stop) begin
                // stop has priority over start and over end-of-pattern done
                r_state <= c_IDLE;
                busy    <= 1'b0;
                mute    <= 1'b1;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        mute <= 1'b1;
                        if (start) begin
                            r_state <= c_FETCH;
                            r_idx   <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    c_FETCH: begin
                        if (w_dur == 5'd0) begin
                            if (loop && (r_idx != '0)) begin
                                r_idx <= '0;
                            end else begin
                                r_state <= c_IDLE;
                                busy    <= 1'b0;
                                mute    <= 1'b1;
                                done    <= 1'b1;
                            end
                        end else begin
                            r_state     <= c_PLAY;
                            pitch       <= w_pitch;
                            waveform    <= w_wave;
                            mute        <= w_rest;
                            r_dur       <= w_dur;
                            r_tlen      <= (tick_len == '0) ? TICK_W'(1) : tick_len;
                            r_tick_cnt  <= '0;
                            r_dur_cnt   <= '0;
                            note_strobe <= 1'b1;
                        end
                    end
                    c_PLAY: begin
                        if (w_tick_last) begin
                            r_tick_cnt <= '0;
                            if (w_dur_last) begin
                                r_state <= c_FETCH;
                                r_idx   <= r_idx + IW'(1);
                            end else begin
                                r_dur_cnt <= r_dur_cnt + 5'd1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        end
                        if (w_gap_enter) begin
                            mute <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                        mute    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/note_sequencer.md
# note_sequencer

Pattern sequencer that drives one synthesizer channel. It steps through a small writable pattern memory of notes (pitch, waveform, duration, rest flag) at a programmable tempo and presents pitch, waveform and mute to the channel. It sits between the host/control logic and a channel instance, and runs in the divided-clock domain.

## Interface
Parameters:
- DEPTH, 16, pattern entries (power of two); IW = $clog2(DEPTH)
- TICK_W, 16, width of tempo tick counter

Ports:
- clk_div  in  1  sequencer clock (divided clock)
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; begin playback at entry 0
- stop  in  1  pulse; abort playback
- loop  in  1  1: wrap to entry 0 at end marker; 0: finish
- tick_len  in  TICK_W  clk_div cycles per tick; 0 treated as 1
- wr_en  in  1  pattern write strobe
- wr_addr  in  IW  pattern write address
- wr_data  in  20  entry {rest[19], waveform[18:17], dur[16:12], pitch[11:0]}
- pitch  out  12  current note pitch to channel
- waveform  out  2  current waveform select to channel
- mute  out  1  1 silences channel
- busy  out  1  1 in FETCH or PLAY
- step_idx  out  IW  index of current entry
- note_strobe  out  1  one-cycle pulse at start of each played note
- done  out  1  one-cycle pulse when pattern ends without loop

## Operation
- States: IDLE, FETCH, PLAY.
- IDLE: mute=1, busy=0. start -> FETCH with idx=0.
- FETCH (1 cycle): registered memory read of entry[idx]. dur==0 is end marker:
  - loop=1 and idx!=0: idx<=0, stay FETCH.
  - loop=0, or marker at idx 0 (empty pattern): -> IDLE, done=1 for 1 cycle.
  - dur!=0: latch pitch/waveform/dur, latch tick_len (0 -> 1), -> PLAY; note_strobe=1 on first PLAY cycle; mute=rest.
- PLAY: tick counter counts T=tick_len cycles per tick, tick count runs dur ticks; after exactly dur*T cycles -> FETCH with idx<=idx+1 (wraps DEPTH-1 -> 0).
- During FETCH between notes, pitch/waveform/mute hold previous note values.
- Writes: accepted every cycle in any state. Read-before-write when wr_addr==idx during FETCH (old data read). Latched note not affected by writes.
- stop: -> IDLE next cycle, mute=1, no done. stop and start same cycle: stop wins. start while busy: ignored.
- Pattern memory not reset; contents persist across rst.

## Timing
- Reset values: pitch=0, waveform=0, mute=1, busy=0, step_idx=0, note_strobe=0, done=0, state IDLE.
- start sampled cycle N -> FETCH cycle N+1 -> first PLAY cycle N+2 (outputs valid, note_strobe high).
- Note period = dur*T + 1 cycles (PLAY + FETCH).
- End marker with loop=0: done and busy=0 in cycle after marker FETCH; mute=1 same cycle.
- rst mid-playback: all outputs to reset values next edge.
- All outputs registered.

## Configuration
- SEQ_GATE_GAP_EN defined: for notes with dur>=2, mute forced to 1 during the final tick of PLAY (articulation gap); dur==1 notes unaffected.
- Undefined: legato; mute=rest for the whole PLAY phase.

## Test plan
- Reset: assert rst 2 cycles -> mute=1, busy=0, pitch=0, step_idx=0.
- Load entries 0:{0,01,3,0x100}, 1:{0,10,1,0x200}, 2:dur=0; tick_len=4, loop=0, start -> pitch 0x100 for 12 cycles, FETCH, 0x200 for 4 cycles, then done pulse, mute=1; two note_strobes.
- Same pattern, loop=1 -> after entry 1, marker FETCH, idx=0 FETCH, pitch 0x100 again; no done.
- Rest entry {1,00,2,0x050} -> mute=1 for 2*T cycles, note_strobe still pulses.
- stop mid-note and start+stop same cycle -> IDLE next cycle, mute=1, done never pulses; empty pattern (entry 0 dur=0, loop=1) -> done after one FETCH.
- With SEQ_GATE_GAP_EN, dur=3, tick_len=4 -> mute=0 for 8 cycles then 1 for 4; dur=1 -> mute=0 whole note.
